// File: rtl/stream_length_finder_if.sv
// stream_length_finder_if: byte-string input stream and length result handshake bundle.
interface stream_length_finder_if #(
  parameter int BYTES_PER_BEAT = 8,
  parameter int MAX_LEN        = 255
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic                        in_valid;
  logic [8*BYTES_PER_BEAT-1:0] in_data;
  logic                        in_last;
  logic                        in_ready;
  logic                        out_valid;
  logic [LEN_W-1:0]            out_length;
  logic                        out_overflow;
  logic                        out_ready;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_length, out_overflow
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_length, out_overflow
  );
endinterface

// File: rtl/stream_length_finder.sv
// stream_length_finder: counts bytes before the first terminator across a multi-beat string,
// reporting a saturated length and overflow flag over a valid/ready result handshake.
module stream_length_finder #(
  parameter int          BYTES_PER_BEAT = 8,
  parameter int          MAX_LEN        = 255,
  parameter logic [7:0]  TERM           = 8'h00
) (
  input logic clk,
  input logic reset_n,
  stream_length_finder_if.slave s
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int SUM_W = $clog2(MAX_LEN + BYTES_PER_BEAT + 2);
  localparam int CNT_W = $clog2(BYTES_PER_BEAT + 1);
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_LEN);
  localparam logic [SUM_W-1:0] SAT_S = SUM_W'(MAX_LEN + 1);
  typedef enum logic [1:0] {SCAN, DRAIN, HOLD} state_t;
  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt;
  logic             found, over;
  // Descending scan so the lowest-index terminator is the one that sticks.
  always_comb begin
    cnt   = CNT_W'(BYTES_PER_BEAT);
    found = 1'b0;
    for (int k = BYTES_PER_BEAT - 1; k >= 0; k--)
      if (s.in_data[8*k +: 8] == TERM) begin
        cnt   = CNT_W'(k);
        found = 1'b1;
      end
  end
  assign sum            = acc_q + SUM_W'(cnt);
  assign over           = sum > MAX_S;
  assign s.in_ready     = state_q != HOLD;
  assign s.out_valid    = state_q == HOLD;
  assign s.out_length   = len_q;
  assign s.out_overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      SCAN: if (s.in_valid) begin
        if (found || s.in_last) begin
          len_d   = over ? LEN_W'(MAX_LEN) : sum[LEN_W-1:0];
          ovf_d   = over;
          state_d = s.in_last ? HOLD : DRAIN;
        end else begin
          acc_d = over ? SAT_S : sum;
        end
      end
      DRAIN: state_d = (s.in_valid && s.in_last) ? HOLD : DRAIN;
      HOLD: if (s.out_ready) begin
        state_d = SCAN;
        acc_d   = '0;
      end
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= SCAN;
      acc_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
endmodule

// File: tb/tb_stream_length_finder.sv
// tb_stream_length_finder: directed scenarios plus random strings checked against a byte-queue model.
module tb_stream_length_finder;
  localparam int BPB = 8;
  localparam int ML  = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  stream_length_finder_if #(.BYTES_PER_BEAT(BPB), .MAX_LEN(ML)) ifc ();
  stream_length_finder #(.BYTES_PER_BEAT(BPB), .MAX_LEN(ML), .TERM(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .s(ifc.slave)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a beat and returns just after the edge that accepts it.
  task automatic send(input logic [63:0] d, input logic last, input string tag);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    while (!ifc.in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready wait"}, 32'(n < 50), 32'd1);
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic take(input int exp_len, input logic exp_ovf, input int stall, input string tag);
    int n = 0;
    while (!ifc.out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, " out_valid"}, 32'(ifc.out_valid), 32'd1);
    check({tag, " length"}, 32'(ifc.out_length), 32'(exp_len));
    check({tag, " overflow"}, 32'(ifc.out_overflow), 32'(exp_ovf));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " held length"}, 32'(ifc.out_length), 32'(exp_len));
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(ifc.out_valid), 32'd0);
  endtask

  // Reference: flatten beats into bytes and count up to the first zero byte.
  task automatic model(input logic [63:0] beats[$], output int len, output logic ovf);
    logic [7:0] bytes[$];
    int n = 0;
    foreach (beats[b])
      for (int k = 0; k < BPB; k++) bytes.push_back(beats[b][8*k +: 8]);
    while (n < bytes.size() && bytes[n] != 8'h00) n++;
    ovf = n > ML;
    len = ovf ? ML : n;
  endtask

  initial begin
    logic [63:0] beats[$];
    int          len;
    logic        ovf;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    #2;
    check("reset out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset out_length", 32'(ifc.out_length), 32'd0);
    check("reset out_overflow", 32'(ifc.out_overflow), 32'd0);
    check("reset in_ready", 32'(ifc.in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single beat, terminator at byte 1
    send(64'hAABBCCDDEEFF00AA, 1'b1, "s1");
    check("s1 latency valid", 32'(ifc.out_valid), 32'd1);
    check("s1 in_ready hold", 32'(ifc.in_ready), 32'd0);
    take(1, 1'b0, 0, "s1");
    check("s1 in_ready after", 32'(ifc.in_ready), 32'd1);

    // 2: terminator in second beat
    send(64'hAABBCCDDEEFFAA99, 1'b0, "s2a");
    check("s2 no early valid", 32'(ifc.out_valid), 32'd0);
    send(64'hAABBCC00EE44FFAA, 1'b1, "s2b");
    check("s2 latency valid", 32'(ifc.out_valid), 32'd1);
    take(12, 1'b0, 0, "s2");

    // 3: terminator in first beat, second beat drained
    send(64'hAABBCCDDEEFFAA00, 1'b0, "s3a");
    check("s3 drain in_ready", 32'(ifc.in_ready), 32'd1);
    check("s3 drain no valid", 32'(ifc.out_valid), 32'd0);
    send(64'h1122334455667788, 1'b1, "s3b");
    check("s3 latency valid", 32'(ifc.out_valid), 32'd1);
    take(0, 1'b0, 0, "s3");

    // 4: saturation
    send(64'h1111111111111111, 1'b0, "s4a");
    send(64'h1111111111111111, 1'b0, "s4b");
    send(64'h1111111111111111, 1'b1, "s4c");
    take(20, 1'b1, 0, "s4");

    // 5: consumer stall with next beat held
    send(64'hAABBCCDDEEFF00AA, 1'b1, "s5a");
    ifc.in_valid = 1'b1;
    ifc.in_data  = 64'h1122334400667788;
    ifc.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s5 stall valid", 32'(ifc.out_valid), 32'd1);
      check("s5 stall length", 32'(ifc.out_length), 32'd1);
      check("s5 stall in_ready", 32'(ifc.in_ready), 32'd0);
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check("s5 handshake drop", 32'(ifc.out_valid), 32'd0);
    check("s5 ready after", 32'(ifc.in_ready), 32'd1);
    tick();
    ifc.in_valid = 1'b0;
    take(3, 1'b0, 0, "s5b");

    // 6: asynchronous reset while holding a result, then mid-string
    send(64'hAABBCCDDEEFF00AA, 1'b1, "s6h");
    check("s6 hold valid", 32'(ifc.out_valid), 32'd1);
    reset_n = 1'b0;
    #2;
    check("s6 async valid", 32'(ifc.out_valid), 32'd0);
    check("s6 async length", 32'(ifc.out_length), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    send(64'hAABBCCDDEEFFAA99, 1'b0, "s6a");
    reset_n = 1'b0;
    #2;
    check("s6 mid valid", 32'(ifc.out_valid), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    send(64'hAABBCCDDEEFFAA00, 1'b1, "s6b");
    take(0, 1'b0, 0, "s6");

    // random strings with idle gaps and consumer stalls
    for (int t = 0; t < 40; t++) begin
      int nb = $urandom_range(1, 4);
      beats.delete();
      for (int b = 0; b < nb; b++) begin
        logic [63:0] d;
        for (int k = 0; k < BPB; k++)
          d[8*k +: 8] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        beats.push_back(d);
      end
      model(beats, len, ovf);
      foreach (beats[b]) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        send(beats[b], 1'(b == nb - 1), "rnd beat");
      end
      take(len, ovf, $urandom_range(0, 3), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
